reg_bank_2w2r: RTL and testbench



---
 rtl/reg_bank_2w2r.sv | 109 ++++++++++
 tb/tb_reg_bank_2w2r.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_2w2r.sv
// reg_bank_2w2r
// Dual-write, dual-read register file for dual-issue / writeback-plus-load
// pipelines. Storage is DATA_WIDTH x 2**ADDR_WIDTH with registered reads
// (one cycle of latency).
//
// Parameters
//   DATA_WIDTH : bits per register
//   ADDR_WIDTH : address bits, depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 = register 0 reads as zero and ignores writes
//   BYPASS     : 1 = a read sees data written at the same edge
//
// Ports
//   clock                           : rising-edge clock
//   clear                           : asynchronous active-high reset
//   readRegA / readRegB             : read addresses
//   dataReadA / dataReadB           : registered read data
//   writeEnA / writeRegA / writeDataA : write port A
//   writeEnB / writeRegB / writeDataB : write port B (wins on collision)
module reg_bank_2w2r #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] readRegA,
  input  logic [ADDR_WIDTH-1:0] readRegB,
  output logic [DATA_WIDTH-1:0] dataReadA,
  output logic [DATA_WIDTH-1:0] dataReadB,
  input  logic                  writeEnA,
  input  logic [ADDR_WIDTH-1:0] writeRegA,
  input  logic [DATA_WIDTH-1:0] writeDataA,
  input  logic                  writeEnB,
  input  logic [ADDR_WIDTH-1:0] writeRegB,
  input  logic [DATA_WIDTH-1:0] writeDataB
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_zero_a;
  logic                  w_zero_b;
  logic                  w_wr_ok_a;
  logic                  w_wr_ok_b;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  // Register 0 is only special when ZERO_REG is set.
  assign w_zero_a = (ZERO_REG != 0) && (writeRegA == '0);
  assign w_zero_b = (ZERO_REG != 0) && (writeRegB == '0);

  // Port B takes priority, so port A is suppressed outright on a collision
  // rather than relying on assignment order.
  assign w_wr_ok_b = writeEnB && !w_zero_b;
  assign w_wr_ok_a = writeEnA && !w_zero_a &&
                     !(w_wr_ok_b && (writeRegA == writeRegB));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok_a) begin
        r_mem[writeRegA] <= writeDataA;
      end
      if (w_wr_ok_b) begin
        r_mem[writeRegB] <= writeDataB;
      end
    end
  end

  // Read selection: the zero register overrides everything, then the
  // forwarded write data (B before A), then stored contents.
  always_comb begin
    w_rd_a = r_mem[readRegA];
    if ((ZERO_REG != 0) && (readRegA == '0)) begin
      w_rd_a = '0;
    end else if ((BYPASS != 0) && w_wr_ok_b && (writeRegB == readRegA)) begin
      w_rd_a = writeDataB;
    end else if ((BYPASS != 0) && w_wr_ok_a && (writeRegA == readRegA)) begin
      w_rd_a = writeDataA;
    end
  end

  always_comb begin
    w_rd_b = r_mem[readRegB];
    if ((ZERO_REG != 0) && (readRegB == '0)) begin
      w_rd_b = '0;
    end else if ((BYPASS != 0) && w_wr_ok_b && (writeRegB == readRegB)) begin
      w_rd_b = writeDataB;
    end else if ((BYPASS != 0) && w_wr_ok_a && (writeRegA == readRegB)) begin
      w_rd_b = writeDataA;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dataReadA <= '0;
      dataReadB <= '0;
    end else begin
      dataReadA <= w_rd_a;
      dataReadB <= w_rd_b;
    end
  end

endmodule

// File: tb/tb_reg_bank_2w2r.sv
// Directed bench for reg_bank_2w2r. Two instances share all inputs:
// dut (ZERO_REG=1, BYPASS=1) and dut_alt (ZERO_REG=0, BYPASS=0).
module tb_reg_bank_2w2r;

  logic        clock;
  logic        clear;
  logic [4:0]  readRegA, readRegB;
  logic [31:0] dataReadA, dataReadB;
  logic [31:0] alt_dataReadA, alt_dataReadB;
  logic        writeEnA, writeEnB;
  logic [4:0]  writeRegA, writeRegB;
  logic [31:0] writeDataA, writeDataB;

  int checks;
  int errors;

  reg_bank_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .clear(clear),
    .readRegA(readRegA), .readRegB(readRegB),
    .dataReadA(dataReadA), .dataReadB(dataReadB),
    .writeEnA(writeEnA), .writeRegA(writeRegA), .writeDataA(writeDataA),
    .writeEnB(writeEnB), .writeRegB(writeRegB), .writeDataB(writeDataB)
  );

  reg_bank_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clock(clock), .clear(clear),
    .readRegA(readRegA), .readRegB(readRegB),
    .dataReadA(alt_dataReadA), .dataReadB(alt_dataReadB),
    .writeEnA(writeEnA), .writeRegA(writeRegA), .writeDataA(writeDataA),
    .writeEnB(writeEnB), .writeRegB(writeRegB), .writeDataB(writeDataB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_writes();
    writeEnA = 1'b0;
    writeEnB = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    readRegA = 5'd0; readRegB = 5'd0;
    writeEnA = 1'b0; writeRegA = 5'd0; writeDataA = 32'h0;
    writeEnB = 1'b0; writeRegB = 5'd0; writeDataB = 32'h0;
    #2 clear = 1'b1;
    #1;
    checks++;
    if (dataReadA !== 32'h0 || dataReadB !== 32'h0) begin
      errors++;
      $display("FAIL reset_initial dut A=%h B=%h want 0 0", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'h0 || alt_dataReadB !== 32'h0) begin
      errors++;
      $display("FAIL reset_initial alt A=%h B=%h want 0 0", alt_dataReadA, alt_dataReadB);
    end
    @(negedge clock);
    clear = 1'b0;

    writeEnA = 1'b1; writeRegA = 5'd5; writeDataA = 32'hDEADBEEF;
    tick();
    idle_writes();
    readRegA = 5'd5; readRegB = 5'd5;
    tick();
    checks++;
    if (dataReadA !== 32'hDEADBEEF || alt_dataReadB !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite dutA=%h altB=%h want deadbeef", dataReadA, alt_dataReadB);
    end
    // asynchronous clear between edges
    clear = 1'b1;
    #1;
    checks++;
    if (dataReadA !== 32'h0 || dataReadB !== 32'h0 || alt_dataReadA !== 32'h0) begin
      errors++;
      $display("FAIL reset_async A=%h B=%h altA=%h want 0", dataReadA, dataReadB, alt_dataReadA);
    end
    #1 clear = 1'b0;
    tick();
    checks++;
    if (dataReadA !== 32'h0 || alt_dataReadA !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5_cleared dutA=%h altA=%h want 0", dataReadA, alt_dataReadA);
    end
    // a write on an edge while clear is held must be discarded
    writeEnA = 1'b1; writeRegA = 5'd6; writeDataA = 32'h1234;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_writes();
    readRegA = 5'd6;
    tick();
    checks++;
    if (dataReadA !== 32'h0 || alt_dataReadA !== 32'h0) begin
      errors++;
      $display("FAIL reset_discard_write dutA=%h altA=%h want 0", dataReadA, alt_dataReadA);
    end
  endtask

  task automatic test_basic();
    writeEnA = 1'b1; writeRegA = 5'd20; writeDataA = 32'd22;
    writeEnB = 1'b1; writeRegB = 5'd7;  writeDataB = 32'd99;
    tick();
    idle_writes();
    readRegA = 5'd20; readRegB = 5'd7;
    tick();
    checks++;
    if (dataReadA !== 32'd22 || dataReadB !== 32'd99) begin
      errors++;
      $display("FAIL basic dut A=%0d B=%0d want 22 99", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'd22 || alt_dataReadB !== 32'd99) begin
      errors++;
      $display("FAIL basic alt A=%0d B=%0d want 22 99", alt_dataReadA, alt_dataReadB);
    end
  endtask

  task automatic test_collision();
    writeEnA = 1'b1; writeRegA = 5'd9; writeDataA = 32'h11;
    writeEnB = 1'b1; writeRegB = 5'd9; writeDataB = 32'h22;
    tick();
    idle_writes();
    readRegA = 5'd9; readRegB = 5'd9;
    tick();
    checks++;
    if (dataReadA !== 32'h22 || dataReadB !== 32'h22) begin
      errors++;
      $display("FAIL collision dut A=%h B=%h want 22 22", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'h22 || alt_dataReadB !== 32'h22) begin
      errors++;
      $display("FAIL collision alt A=%h B=%h want 22 22", alt_dataReadA, alt_dataReadB);
    end
  endtask

  task automatic test_bypass();
    writeEnA = 1'b1; writeRegA = 5'd3; writeDataA = 32'd5;
    tick();
    writeDataA = 32'd8;
    readRegA = 5'd3; readRegB = 5'd3;
    tick();
    idle_writes();
    checks++;
    if (dataReadA !== 32'd8 || dataReadB !== 32'd8) begin
      errors++;
      $display("FAIL bypass_on A=%0d B=%0d want 8 8", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'd5) begin
      errors++;
      $display("FAIL bypass_off A=%0d want 5", alt_dataReadA);
    end
    tick();
    checks++;
    if (alt_dataReadA !== 32'd8 || dataReadA !== 32'd8) begin
      errors++;
      $display("FAIL bypass_after altA=%0d dutA=%0d want 8 8", alt_dataReadA, dataReadA);
    end
    // forwarding on a collision must pick port B's data
    writeEnA = 1'b1; writeRegA = 5'd4; writeDataA = 32'd1;
    writeEnB = 1'b1; writeRegB = 5'd4; writeDataB = 32'd2;
    readRegA = 5'd4; readRegB = 5'd4;
    tick();
    idle_writes();
    checks++;
    if (dataReadA !== 32'd2 || dataReadB !== 32'd2) begin
      errors++;
      $display("FAIL bypass_collision A=%0d B=%0d want 2 2", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'd0) begin
      errors++;
      $display("FAIL bypass_collision_off A=%0d want 0", alt_dataReadA);
    end
  endtask

  task automatic test_zero_reg();
    writeEnA = 1'b1; writeRegA = 5'd0; writeDataA = 32'hFFFF;
    writeEnB = 1'b1; writeRegB = 5'd0; writeDataB = 32'hFFFF;
    readRegA = 5'd0; readRegB = 5'd0;
    tick();
    idle_writes();
    checks++;
    if (dataReadA !== 32'h0 || dataReadB !== 32'h0) begin
      errors++;
      $display("FAIL zero_same_cycle A=%h B=%h want 0 0", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'h0) begin
      errors++;
      $display("FAIL zero_alt_prewrite A=%h want 0", alt_dataReadA);
    end
    tick();
    checks++;
    if (dataReadA !== 32'h0 || dataReadB !== 32'h0) begin
      errors++;
      $display("FAIL zero_next_cycle A=%h B=%h want 0 0", dataReadA, dataReadB);
    end
    checks++;
    if (alt_dataReadA !== 32'hFFFF || alt_dataReadB !== 32'hFFFF) begin
      errors++;
      $display("FAIL zero_reg_off A=%h B=%h want ffff ffff", alt_dataReadA, alt_dataReadB);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_a, exp_b;
    for (int i = 0; i < 32; i += 2) begin
      writeEnA = 1'b1; writeRegA = 5'(i);     writeDataA = 32'(i * 3);
      writeEnB = 1'b1; writeRegB = 5'(i + 1); writeDataB = 32'((i + 1) * 3);
      tick();
    end
    idle_writes();
    for (int i = 0; i < 32; i++) begin
      readRegA = 5'(i);
      readRegB = 5'(31 - i);
      tick();
      exp_a = 32'(i * 3);
      exp_b = 32'((31 - i) * 3);
      checks++;
      if (dataReadA !== exp_a || dataReadB !== exp_b) begin
        errors++;
        $display("FAIL sweep dut i=%0d A=%0d B=%0d want %0d %0d", i, dataReadA, dataReadB, exp_a, exp_b);
      end
      checks++;
      if (alt_dataReadA !== exp_a || alt_dataReadB !== exp_b) begin
        errors++;
        $display("FAIL sweep alt i=%0d A=%0d B=%0d want %0d %0d", i, alt_dataReadA, alt_dataReadB, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    // consecutive writes to one address, read every edge with forwarding
    writeEnB = 1'b1; writeRegB = 5'd12;
    readRegA = 5'd12;
    writeDataB = 32'hA1;
    tick();
    checks++;
    if (dataReadA !== 32'hA1 || alt_dataReadA !== 32'd36) begin
      errors++;
      $display("FAIL b2b_first dutA=%h altA=%h want a1 24", dataReadA, alt_dataReadA);
    end
    writeDataB = 32'hA2;
    tick();
    idle_writes();
    checks++;
    if (dataReadA !== 32'hA2 || alt_dataReadA !== 32'hA1) begin
      errors++;
      $display("FAIL b2b_second dutA=%h altA=%h want a2 a1", dataReadA, alt_dataReadA);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
